// File: rtl/test_exit_monitor.sv
// Exit monitor: decodes tohost exit and syscall writes, runs a retire watchdog, and drives sticky pass/fail status.
// Latency: one cycle. Every output is a register that updates on the accepting edge or on the watchdog-expiry edge.
// Backpressure: ready is high only in RUN, from the first edge after reset. PASS and FAIL hold ready low, which stalls the DUT.
module test_exit_monitor #(
   parameter int XLEN        = 64,
   parameter int WDOG_CYCLES = 1000000,
   parameter bit SYSCALL_OK  = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            io_tohost_valid,
   output logic            io_tohost_ready,
   input  logic [XLEN-1:0] io_tohost_bits,
   input  logic            io_retire,
   output logic            io_success,
   output logic            io_failure,
   output logic [1:0]      io_reason,
   output logic [XLEN-2:0] io_exit_code,
   output logic [15:0]     io_syscall_count
);

   localparam bit WDOG_EN = (WDOG_CYCLES > 0);
   localparam int CNT_W   = WDOG_EN ? $clog2(WDOG_CYCLES + 1) : 1;
   // Counter value from which one more idle edge means a hang
   localparam logic [CNT_W-1:0] WDOG_LAST = WDOG_EN ? CNT_W'(WDOG_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PASS = 2'd1,
      FAIL = 2'd2
   } state_t;

   state_t          state;
   logic [CNT_W-1:0] wdog_cnt;

   logic            accept;
   logic            exit_wr;
   logic            exit_ok;
   logic            sys_wr;
   logic            proto_err;
   logic            expire;
   logic [XLEN-2:0] payload;

   // Classify the write offered on this edge and decide whether the watchdog runs out
   always_comb begin
      payload   = io_tohost_bits[XLEN-1:1];
      accept    = io_tohost_valid && io_tohost_ready;
      exit_wr   = accept && io_tohost_bits[0];
      exit_ok   = exit_wr && (payload == '0);
      // A value with bit 0 clear is nonzero exactly when its upper bits are nonzero
      sys_wr    = accept && !io_tohost_bits[0] && (payload != '0);
      proto_err = sys_wr && !SYSCALL_OK;
      expire    = WDOG_EN && (state == RUN) && !io_retire && (wdog_cnt == WDOG_LAST);
   end

   // Update state, sticky status and the watchdog; a terminal state freezes all of them
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= RUN;
         io_tohost_ready  <= 1'b0;
         io_success       <= 1'b0;
         io_failure       <= 1'b0;
         io_reason        <= 2'd0;
         io_exit_code     <= '0;
         io_syscall_count <= 16'd0;
         wdog_cnt         <= '0;
      end else begin
         case (state)
            RUN: begin
               io_tohost_ready <= 1'b1;
               if (WDOG_EN) begin
                  if (io_retire) begin
                     wdog_cnt <= '0;
                  end else if (!expire) begin
                     wdog_cnt <= wdog_cnt + CNT_W'(1);
                  end
               end
               // A syscall counts even on the expiry edge
               if (sys_wr && SYSCALL_OK && (io_syscall_count != 16'hFFFF)) begin
                  io_syscall_count <= io_syscall_count + 16'd1;
               end
               // A terminating write takes priority over watchdog expiry
               if (exit_ok) begin
                  state           <= PASS;
                  io_success      <= 1'b1;
                  io_tohost_ready <= 1'b0;
               end else if (exit_wr || proto_err) begin
                  state           <= FAIL;
                  io_failure      <= 1'b1;
                  io_reason       <= exit_wr ? 2'd1 : 2'd3;
                  io_exit_code    <= payload;
                  io_tohost_ready <= 1'b0;
               end else if (expire) begin
                  state           <= FAIL;
                  io_failure      <= 1'b1;
                  io_reason       <= 2'd2;
                  io_exit_code    <= '0;
                  io_tohost_ready <= 1'b0;
               end
            end
            default: begin
               io_tohost_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_test_exit_monitor.sv
// Bench for test_exit_monitor: two instances (syscalls allowed / syscalls illegal) share one stimulus stream.
// A cycle-level behavioural model predicts every output of both instances; directed literal checks pin the model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_test_exit_monitor;

   localparam int WDOG = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        tohost_valid = 1'b0;
   logic [63:0] tohost_bits = 64'd0;
   logic        retire = 1'b0;

   logic        a_ready, a_success, a_failure;
   logic [1:0]  a_reason;
   logic [62:0] a_code;
   logic [15:0] a_count;
   logic        b_ready, b_success, b_failure;
   logic [1:0]  b_reason;
   logic [62:0] b_code;
   logic [15:0] b_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   test_exit_monitor #(.XLEN(64), .WDOG_CYCLES(WDOG), .SYSCALL_OK(1'b1)) dut_a (
      .clock(clock), .reset(reset),
      .io_tohost_valid(tohost_valid), .io_tohost_ready(a_ready), .io_tohost_bits(tohost_bits),
      .io_retire(retire), .io_success(a_success), .io_failure(a_failure), .io_reason(a_reason),
      .io_exit_code(a_code), .io_syscall_count(a_count)
   );

   test_exit_monitor #(.XLEN(64), .WDOG_CYCLES(WDOG), .SYSCALL_OK(1'b0)) dut_b (
      .clock(clock), .reset(reset),
      .io_tohost_valid(tohost_valid), .io_tohost_ready(b_ready), .io_tohost_bits(tohost_bits),
      .io_retire(retire), .io_success(b_success), .io_failure(b_failure), .io_reason(b_reason),
      .io_exit_code(b_code), .io_syscall_count(b_count)
   );

   // Behavioural model: pass/fail flags, cycles since last retire, saturating syscall tally
   typedef struct packed {
      bit          pass;
      bit          fail;
      bit [1:0]    reason;
      bit [62:0]   code;
      int unsigned count;
      int unsigned idle;
      bit          ready;
   } model_t;

   model_t ma = '0;
   model_t mb = '0;

   function automatic model_t step(model_t m, bit sok, bit valid, bit [63:0] v, bit ret);
      model_t n;
      bit done;
      n = m;
      if (m.pass || m.fail) return n;
      done = 1'b0;
      if (valid && m.ready && (v != 64'd0)) begin
         if (v[0]) begin
            done = 1'b1;
            if (v[63:1] == 63'd0) n.pass = 1'b1;
            else begin n.fail = 1'b1; n.reason = 2'd1; n.code = v[63:1]; end
         end else if (sok) begin
            if (n.count < 65535) n.count = n.count + 1;
         end else begin
            done = 1'b1; n.fail = 1'b1; n.reason = 2'd3; n.code = v[63:1];
         end
      end
      n.idle = ret ? 0 : m.idle + 1;
      if (!done && n.idle >= WDOG) begin
         n.fail = 1'b1; n.reason = 2'd2; n.code = 63'd0;
      end
      n.ready = !(n.pass || n.fail);
      return n;
   endfunction

   // Advance both models on every edge; an asserted reset returns them to the reset picture at once
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         ma = '0;
         mb = '0;
      end else begin
         ma = step(ma, 1'b1, tohost_valid, tohost_bits, retire);
         mb = step(mb, 1'b0, tohost_valid, tohost_bits, retire);
      end
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic cmp(string tag, model_t m, logic rdy, logic suc, logic fl, logic [1:0] rsn,
                      logic [62:0] code, logic [15:0] cnt);
      check({tag, ".ready"},   64'(rdy),  64'(m.ready));
      check({tag, ".success"}, 64'(suc),  64'(m.pass));
      check({tag, ".failure"}, 64'(fl),   64'(m.fail));
      check({tag, ".reason"},  64'(rsn),  64'(m.reason));
      check({tag, ".code"},    64'(code), 64'(m.code));
      check({tag, ".count"},   64'(cnt),  64'(m.count));
      if (suc && fl) check({tag, ".both_set"}, 64'd1, 64'd0);
   endtask

   // Compare both instances with the model on every cycle
   always @(negedge clock) begin
      cmp("a", ma, a_ready, a_success, a_failure, a_reason, a_code, a_count);
      cmp("b", mb, b_ready, b_success, b_failure, b_reason, b_code, b_count);
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic write(logic [63:0] v);
      tohost_valid = 1'b1;
      tohost_bits  = v;
      tick(1);
      tohost_valid = 1'b0;
      tohost_bits  = 64'd0;
   endtask

   // Assert reset between edges, then release it one unit after an edge
   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
   endtask

   initial begin
      // Reset state
      tick(3);
      check("rst_ready", 64'(a_ready), 64'd0);
      check("rst_success", 64'(a_success), 64'd0);
      check("rst_count", 64'(a_count), 64'd0);
      reset = 1'b1;

      // Syscalls and ignored zero writes; the strict instance rejects the first syscall
      retire = 1'b1;
      tick(1);
      check("ready_after_release", 64'(a_ready), 64'd1);
      write(64'h8000_1000);
      check("b_proto_reason", 64'(b_reason), 64'd3);
      check("b_proto_code", 64'(b_code), 64'h4000_0800);
      write(64'h8000_1000);
      write(64'h8000_1000);
      write(64'h0);
      write(64'h0);
      check("sys_count3", 64'(a_count), 64'd3);
      check("sys_still_run", 64'(a_ready), 64'd1);

      // Retire on the would-be expiry edge, then regular retires, then a hang
      do_reset();
      retire = 1'b0;
      tick(WDOG - 1);
      retire = 1'b1;
      tick(1);
      for (int i = 0; i < 20; i++) begin
         retire = 1'b0;
         tick(9);
         retire = 1'b1;
         tick(1);
      end
      check("wdog_no_fail", 64'(a_failure), 64'd0);
      retire = 1'b0;
      tick(WDOG - 1);
      check("wdog_edge_minus1", 64'(a_failure), 64'd0);
      tick(1);
      check("wdog_fail", 64'(a_failure), 64'd1);
      check("wdog_reason", 64'(a_reason), 64'd2);

      // Asynchronous reset between edges clears outputs without a clock
      #1;
      reset = 1'b0;
      #1;
      check("async_failure", 64'(a_failure), 64'd0);
      check("async_reason", 64'(a_reason), 64'd0);
      check("async_ready", 64'(a_ready), 64'd0);
      tick(2);
      reset = 1'b1;

      // Exit write lands on the watchdog expiry edge: pass wins
      tick(WDOG - 1);
      write(64'h1);
      check("pass_success", 64'(a_success), 64'd1);
      check("pass_failure", 64'(a_failure), 64'd0);
      check("pass_ready", 64'(a_ready), 64'd0);
      tick(100);
      check("pass_sticky", 64'(a_success), 64'd1);

      // Backpressure in PASS: the write is never taken
      tohost_valid = 1'b1;
      tohost_bits  = 64'h3;
      tick(10);
      tohost_valid = 1'b0;
      tohost_bits  = 64'd0;
      check("bp_code", 64'(a_code), 64'd0);
      check("bp_success", 64'(a_success), 64'd1);

      // Failing exit code
      do_reset();
      retire = 1'b1;
      tick(1);
      write(64'h55);
      check("fail_failure", 64'(a_failure), 64'd1);
      check("fail_reason", 64'(a_reason), 64'd1);
      check("fail_code", 64'(a_code), 64'h2A);
      check("fail_success", 64'(a_success), 64'd0);
      tick(5);

      // Syscall on the expiry edge: counted, and the hang still fails the test
      do_reset();
      retire = 1'b0;
      tick(WDOG - 1);
      write(64'h8000_1000);
      check("sysexp_count", 64'(a_count), 64'd1);
      check("sysexp_reason", 64'(a_reason), 64'd2);
      check("sysexp_b_reason", 64'(b_reason), 64'd3);

      // Saturation of the syscall counter
      do_reset();
      retire = 1'b1;
      tick(1);
      tohost_valid = 1'b1;
      tohost_bits  = 64'h8000_1000;
      tick(65540);
      tohost_valid = 1'b0;
      tohost_bits  = 64'd0;
      check("sat_count", 64'(a_count), 64'hFFFF);
      check("sat_run", 64'(a_ready), 64'd1);
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
